// File: rtl/sh_sync.sv
// Bit-period sync generator: locks a phase counter to RF pulses in receive mode,
// free-runs it in transmit mode, and emits shift-enable / FSM-reset strobes.
module sh_sync #(
  parameter int BIT_PERIOD = 10000,
  parameter int SAMPLE_OFS = 5000,
  parameter int LOST_BITS  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rfin,
  input  logic RX,
  input  logic tx_rdy,
  output logic sh_en,
  output logic fsm_rst
);

  localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int MW = $clog2(LOST_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_OFS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [MW-1:0] MISS_LIMIT = MW'(LOST_BITS - 1);
  localparam logic [MW-1:0] MISS_MAX   = MW'(LOST_BITS);
  localparam logic [MW-1:0] MISS_ONE   = MW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RX_LOCK  = 2'd1,
    TX_SHIFT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [MW-1:0] miss_q, miss_d;
  logic [2:0]    sync_q;
  logic          sh_en_q, sh_en_d;
  logic          fsm_rst_q, fsm_rst_d;
  logic          pulse;

  // sync_q[1:0] is the metastability pair; sync_q[2] is the edge-detect history.
  assign pulse   = sync_q[1] & ~sync_q[2];
  assign cnt_inc = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    miss_d    = miss_q;
    sh_en_d   = 1'b0;
    fsm_rst_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (RX && pulse) begin
          state_d = RX_LOCK;
          miss_d  = '0;
        end else if (!RX && tx_rdy) begin
          state_d = TX_SHIFT;
        end
      end
      RX_LOCK: begin
        if (!RX) begin
          fsm_rst_d = 1'b1;
          cnt_d     = '0;
          miss_d    = '0;
          state_d   = tx_rdy ? TX_SHIFT : IDLE;
        end else if (pulse) begin
          // Realign phase; a coincident sample strobe is dropped.
          cnt_d  = '0;
          miss_d = '0;
        end else begin
          cnt_d   = cnt_inc;
          sh_en_d = (cnt_inc == CNT_SAMPLE);
          if (cnt_q == CNT_LAST) begin
            if (miss_q == MISS_LIMIT) begin
              fsm_rst_d = 1'b1;
              sh_en_d   = 1'b0;
              state_d   = IDLE;
              cnt_d     = '0;
              miss_d    = '0;
            end else if (miss_q != MISS_MAX) begin
              miss_d = miss_q + MISS_ONE;
            end
          end
        end
      end
      TX_SHIFT: begin
        if (RX) begin
          fsm_rst_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (tx_rdy) begin
          cnt_d   = cnt_inc;
          sh_en_d = (cnt_inc == CNT_LAST);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        miss_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      miss_q    <= '0;
      sync_q    <= '0;
      sh_en_q   <= 1'b0;
      fsm_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      miss_q    <= miss_d;
      sync_q    <= {sync_q[1:0], rfin};
      sh_en_q   <= sh_en_d;
      fsm_rst_q <= fsm_rst_d;
    end
  end

  assign sh_en   = sh_en_q;
  assign fsm_rst = fsm_rst_q;

endmodule

// File: tb/tb_sh_sync.sv
// Directed bench for sh_sync with a shortened bit period; timings are counted
// in clock edges from the cycle in which the raw rfin pulse is raised.
`timescale 1ns/1ps
module tb_sh_sync;
  localparam int BP   = 200;
  localparam int SO   = 100;
  localparam int LB   = 16;
  localparam int JOFS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rfin = 1'b0;
  logic RX = 1'b0;
  logic tx_rdy = 1'b0;
  logic sh_en;
  logic fsm_rst;

  sh_sync #(.BIT_PERIOD(BP), .SAMPLE_OFS(SO), .LOST_BITS(LB)) dut (
    .clk(clk), .rst(rst), .rfin(rfin), .RX(RX), .tx_rdy(tx_rdy),
    .sh_en(sh_en), .fsm_rst(fsm_rst)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int sh_cnt = 0, fr_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (sh_en === 1'b1) sh_cnt <= sh_cnt + 1;
    if (fsm_rst === 1'b1) fr_cnt <= fr_cnt + 1;
    if (sh_en === 1'b1 && fsm_rst === 1'b1) both_cnt <= both_cnt + 1;
  end

  int n_cmp = 0, n_fail = 0;
  int joff [8] = '{0, 20, -15, 7, -20, 13, -9, 20};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic at_cycle(input int n, input string tag);
    while (cyc < n) tick(1);
    if (cyc != n) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s_sched: observed cycle %0d expected %0d", tag, cyc, n);
    end
  endtask

  task automatic pulse_at(input int n, output int p);
    at_cycle(n, "pulse");
    rfin = 1'b1;
    p = cyc;
    tick(1);
    rfin = 1'b0;
  endtask

  task automatic expect_sh(input int n, input string tag);
    at_cycle(n - 1, tag);
    chk({tag, "_pre"}, 32'(sh_en), 32'd0);
    tick(1);
    chk(tag, 32'(sh_en), 32'd1);
  endtask

  initial begin
    logic [76:0] pat;
    int p, q, t, r, tmp, base, slot, last, c0, f0;

    // Reset held with rfin toggling: both outputs stay low.
    rst = 1'b0; RX = 1'b1; tx_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rfin = ~rfin;
      tick(1);
      chk("rst_sh_en", 32'(sh_en), 32'd0);
      chk("rst_fsm_rst", 32'(fsm_rst), 32'd0);
    end
    rfin = 1'b0;
    rst = 1'b1;
    tick(2 * BP);
    chk("idle_no_strobe", sh_cnt, 0);
    chk("idle_no_fsm_rst", fr_cnt, 0);

    // Acquisition and flywheel.
    c0 = sh_cnt;
    pulse_at(cyc + 5, p);
    expect_sh(p + 3 + SO, "acq_first");
    expect_sh(p + 3 + SO + BP, "acq_fly1");
    expect_sh(p + 3 + SO + 2 * BP, "acq_fly2");
    chk("acq_count", sh_cnt - c0, 3);

    // 77-bit sync frame, pulses at a 1% offset into each period.
    pat = {8'b11111111, 1'b0, 16'b1010110010010110, 8'b11111111, 1'b0,
           16'b0110101000110101, 16'b1001011011001011, 11'b01011010011};
    c0 = sh_cnt; f0 = fr_cnt;
    base = p + 3 * BP - JOFS;
    last = 0;
    for (int k = 0; k < 77; k++) begin
      slot = base + k * BP + JOFS;
      if (pat[76 - k]) begin
        pulse_at(slot, tmp);
        last = slot;
      end
      expect_sh(slot + 3 + SO, $sformatf("frame_bit%0d", k));
    end
    chk("frame_strobes", sh_cnt - c0, 77);
    chk("frame_no_fsm_rst", fr_cnt - f0, 0);

    // Loss of lock after LB pulse-free periods.
    c0 = sh_cnt; f0 = fr_cnt;
    at_cycle(last + 3 + LB * BP - 1, "loss");
    chk("loss_pre", 32'(fsm_rst), 32'd0);
    tick(1);
    chk("loss_fsm_rst", 32'(fsm_rst), 32'd1);
    chk("loss_no_sh", 32'(sh_en), 32'd0);
    tick(1);
    chk("loss_one_clk", 32'(fsm_rst), 32'd0);
    chk("loss_flywheel_strobes", sh_cnt - c0, LB - 1);
    tick(2 * BP);
    chk("post_loss_idle", sh_cnt - c0, LB - 1);
    chk("loss_fsm_rst_count", fr_cnt - f0, 1);

    // Mode switch: RX falls while locked, tx_rdy follows 500 ns later.
    pulse_at(cyc + 3, p);
    expect_sh(p + 3 + SO, "relock");
    f0 = fr_cnt;
    tick(10);
    RX = 1'b0;
    r = cyc;
    tick(1);
    chk("rxfall_fsm_rst", 32'(fsm_rst), 32'd1);
    tick(4);
    tx_rdy = 1'b1;
    t = cyc;
    chk("rxfall_one_pulse", fr_cnt - f0, 1);
    c0 = sh_cnt;
    expect_sh(t + BP, "tx_1");
    pulse_at(t + BP + 20, tmp);
    expect_sh(t + 2 * BP, "tx_2");
    expect_sh(t + 3 * BP, "tx_3");
    chk("tx_count", sh_cnt - c0, 3);
    at_cycle(t + 3 * BP + 50, "tx_stop");
    tx_rdy = 1'b0;
    tick(3 * BP);
    chk("tx_stopped", sh_cnt - c0, 3);
    chk("modeswitch_fsm_rst_count", fr_cnt - f0, 1);

    // Leaving transmit mode when RX rises.
    RX = 1'b1;
    tick(1);
    chk("tx_exit_fsm_rst", 32'(fsm_rst), 32'd1);
    chk("tx_exit_no_sh", 32'(sh_en), 32'd0);
    tick(1);
    chk("tx_exit_one_clk", 32'(fsm_rst), 32'd0);

    // Jittered pulses: each strobe follows its own pulse.
    c0 = sh_cnt; f0 = fr_cnt;
    base = cyc + 10;
    for (int k = 0; k < 8; k++) begin
      pulse_at(base + k * BP + joff[k], p);
      expect_sh(p + 3 + SO, $sformatf("jitter%0d", k));
    end
    // Pulse detected on the sample cycle: reload wins, strobe moves.
    pulse_at(p + BP, p);
    pulse_at(p + SO, q);
    at_cycle(q + 3, "coinc");
    chk("coinc_no_sh", 32'(sh_en), 32'd0);
    expect_sh(q + 3 + SO, "coinc_realigned");
    chk("jitter_count", sh_cnt - c0, 9);
    chk("jitter_no_loss", fr_cnt - f0, 0);

    // Asynchronous reset mid-lock aborts lock; next pulse re-acquires.
    c0 = sh_cnt;
    tick(20);
    #20 rst = 1'b0;
    #5 chk("midrst_sh", 32'(sh_en), 32'd0);
    chk("midrst_fsm_rst", 32'(fsm_rst), 32'd0);
    tick(3);
    rst = 1'b1;
    tick(2 * BP);
    chk("midrst_lock_aborted", sh_cnt - c0, 0);
    pulse_at(cyc + 7, p);
    expect_sh(p + 3 + SO, "reacq");
    expect_sh(p + 3 + SO + BP, "reacq_fly");

    chk("never_both", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
